// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - fetch program-counter controller with redirect priority and return-address stack
module pc_ctrl #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180,
    parameter int unsigned           RAS_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fetch_rdy,
    input  logic                  exc_valid,
    input  logic                  jr_valid,
    input  logic [DATA_WIDTH-1:0] jr_target,
    input  logic                  j_valid,
    input  logic [25:0]           j_index,
    input  logic                  br_taken,
    input  logic [15:0]           br_offset,
    input  logic                  link,
    input  logic                  ret,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_plus4,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] ras_top,
    output logic                  ras_empty,
    output logic                  ras_full,
    output logic                  addr_err
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FLUSH} state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  fetch_valid_q;
    logic                  addr_err_q;
    logic [DATA_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]         ras_sp_q;
    logic [CW-1:0]         ras_cnt_q;

    logic                  redirect;
    logic                  take_jr;
    logic                  take_j;
    logic                  jr_misaligned;
    logic                  do_push;
    logic                  do_pop;
    logic [PW-1:0]         push_idx;
    logic [DATA_WIDTH-1:0] target_d;

    assign pc_plus4 = pc_q + DATA_WIDTH'(4);

    always_comb begin
        redirect      = exc_valid | jr_valid | j_valid | br_taken;
        take_jr       = !exc_valid && jr_valid;
        take_j        = !exc_valid && !jr_valid && j_valid;
        jr_misaligned = take_jr && (jr_target[1:0] != 2'b00);
        do_push       = link && (take_jr || take_j);
        do_pop        = ret && take_jr;
        push_idx      = ras_sp_q + PW'(1);
        target_d      = pc_plus4 + {{(DATA_WIDTH-18){br_offset[15]}}, br_offset, 2'b00};
        if (exc_valid || jr_misaligned) begin
            target_d = EXC_VECTOR;
        end else if (take_jr) begin
            target_d = jr_target;
        end else if (take_j) begin
            target_d = {pc_plus4[DATA_WIDTH-1:28], j_index, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            ras_sp_q      <= '0;
            ras_cnt_q     <= '0;
        end else begin
            addr_err_q <= 1'b0;
            if (en) begin
                case (state_q)
                    ST_RUN: begin
                        if (redirect) begin
                            pc_q          <= target_d;
                            state_q       <= ST_FLUSH;
                            fetch_valid_q <= 1'b0;
                            addr_err_q    <= jr_misaligned;
                            if (exc_valid) begin
                                ras_cnt_q <= '0;
                            end else if (do_push && do_pop) begin
                                ras_q[ras_sp_q] <= pc_plus4;
                            end else if (do_push) begin
                                // Circular: a push when full silently overwrites the oldest slot.
                                ras_q[push_idx] <= pc_plus4;
                                ras_sp_q        <= push_idx;
                                if (ras_cnt_q != CW'(RAS_DEPTH)) begin
                                    ras_cnt_q <= ras_cnt_q + CW'(1);
                                end
                            end else if (do_pop && ras_cnt_q != '0) begin
                                ras_sp_q  <= ras_sp_q - PW'(1);
                                ras_cnt_q <= ras_cnt_q - CW'(1);
                            end
                        end else if (fetch_rdy) begin
                            pc_q <= pc_plus4;
                        end
                    end
                    // BOOT and FLUSH are one-cycle fetch bubbles; redirects are ignored there.
                    ST_BOOT, ST_FLUSH: begin
                        state_q       <= ST_RUN;
                        fetch_valid_q <= 1'b1;
                    end
                    default: begin
                        state_q       <= ST_BOOT;
                        fetch_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign addr_err    = addr_err_q;
    assign ras_empty   = (ras_cnt_q == '0);
    assign ras_full    = (ras_cnt_q == CW'(RAS_DEPTH));
    assign ras_top     = ras_empty ? '0 : ras_q[ras_sp_q];

endmodule

// File: tb/tb_pc_ctrl.sv
// tb/tb_pc_ctrl.sv - self-checking bench for pc_ctrl: vector table, RAS/reset sequences, random vs model
module tb_pc_ctrl;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RST_V = 32'h0000_0000;
    localparam logic [31:0] EXC_V = 32'h0000_0180;
    localparam int P_BOOT = 0, P_RUN = 1, P_FLUSH = 2;

    logic        clk = 1'b0;
    logic        rst, en, fetch_rdy, exc_valid, jr_valid, j_valid, br_taken, link, ret;
    logic [31:0] jr_target;
    logic [25:0] j_index;
    logic [15:0] br_offset;
    logic [31:0] pc, pc_plus4, ras_top;
    logic        fetch_valid, ras_empty, ras_full, addr_err;

    int n_vec  = 0;
    int n_fail = 0;

    pc_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .fetch_rdy(fetch_rdy),
        .exc_valid(exc_valid), .jr_valid(jr_valid), .jr_target(jr_target),
        .j_valid(j_valid), .j_index(j_index), .br_taken(br_taken), .br_offset(br_offset),
        .link(link), .ret(ret), .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
        .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ctl;    // {en, fetch_rdy, exc, jr, j, br, link, ret}
        logic [31:0] tgt;
        logic [25:0] jidx;
        logic [15:0] boff;
        logic [31:0] e_pc;
        logic [3:0]  e_flags; // {fetch_valid, addr_err, ras_empty, ras_full}
        logic [31:0] e_top;
    } vec_t;

    function automatic vec_t mk(logic [7:0] ctl, logic [31:0] tgt, logic [25:0] jidx,
                                logic [15:0] boff, logic [31:0] e_pc, logic [3:0] e_flags,
                                logic [31:0] e_top);
        vec_t v;
        v.ctl = ctl; v.tgt = tgt; v.jidx = jidx; v.boff = boff;
        v.e_pc = e_pc; v.e_flags = e_flags; v.e_top = e_top;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] e_pc, logic e_fv, logic e_aerr,
                         logic e_empty, logic e_full, logic [31:0] e_top);
        n_vec++;
        if (pc !== e_pc || pc_plus4 !== e_pc + 32'd4 || fetch_valid !== e_fv ||
            addr_err !== e_aerr || ras_empty !== e_empty || ras_full !== e_full ||
            ras_top !== e_top) begin
            n_fail++;
            $display("FAIL %s: got pc=%h pp4=%h fv=%b aerr=%b empty=%b full=%b top=%h; need pc=%h pp4=%h fv=%b aerr=%b empty=%b full=%b top=%h",
                     name, pc, pc_plus4, fetch_valid, addr_err, ras_empty, ras_full, ras_top,
                     e_pc, e_pc + 32'd4, e_fv, e_aerr, e_empty, e_full, e_top);
        end
    endtask

    task automatic set_in(vec_t v);
        {en, fetch_rdy, exc_valid, jr_valid, j_valid, br_taken, link, ret} = v.ctl;
        jr_target = v.tgt;
        j_index   = v.jidx;
        br_offset = v.boff;
    endtask

    task automatic apply(string name, vec_t v);
        set_in(v);
        step();
        check(name, v.e_pc, v.e_flags[3], v.e_flags[2], v.e_flags[1], v.e_flags[0], v.e_top);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(mk(8'b1111_1111, 32'h0000_0203, 26'h3, 16'h1, 32'h0, 4'h0, 32'h0));
        step();
        rst = 1'b0;
    endtask

    // Reference model: architectural PC, bubble phase, RAS as a queue (front = oldest, back = top).
    logic [31:0] m_pc;
    int          m_phase;
    logic        m_fv, m_aerr;
    logic [31:0] m_ras[$];

    task automatic ras_model(logic push, logic pop, logic [31:0] val);
        if (push && pop) begin
            if (m_ras.size() > 0) m_ras[m_ras.size()-1] = val;
        end else if (push) begin
            if (m_ras.size() == DEPTH) m_ras.delete(0);
            m_ras.push_back(val);
        end else if (pop) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
        end
    endtask

    task automatic model_step();
        logic [31:0] pp;
        if (rst) begin
            m_pc = RST_V; m_phase = P_BOOT; m_fv = 1'b0; m_aerr = 1'b0;
            m_ras.delete();
        end else begin
            m_aerr = 1'b0;
            if (en) begin
                if (m_phase != P_RUN) begin
                    m_phase = P_RUN;
                    m_fv    = 1'b1;
                end else begin
                    pp = m_pc + 32'd4;
                    if (exc_valid) begin
                        m_pc = EXC_V;
                        m_ras.delete();
                    end else if (jr_valid) begin
                        if (jr_target % 4 != 0) begin
                            m_pc   = EXC_V;
                            m_aerr = 1'b1;
                        end else begin
                            m_pc = jr_target;
                        end
                        ras_model(link, ret, pp);
                    end else if (j_valid) begin
                        m_pc = (pp & 32'hF000_0000) | (32'(j_index) * 32'd4);
                        ras_model(link, 1'b0, pp);
                    end else if (br_taken) begin
                        m_pc = pp + 32'($signed(br_offset)) * 32'd4;
                    end else if (fetch_rdy) begin
                        m_pc = pp;
                    end
                    if (exc_valid || jr_valid || j_valid || br_taken) begin
                        m_phase = P_FLUSH;
                        m_fv    = 1'b0;
                    end
                end
            end
        end
    endtask

    vec_t tbl[19];
    logic [31:0] push_pc[5]  = '{32'h40, 32'h80, 32'hC0, 32'h100, 32'h140};
    logic [31:0] push_top[5] = '{32'h4, 32'h44, 32'h84, 32'hC4, 32'h104};
    logic [31:0] pop_top[5]  = '{32'hC4, 32'h84, 32'h44, 32'h0, 32'h0};

    initial begin
        tbl[0]  = mk(8'b1100_0000, 32'h0,   26'h0,  16'h0,    32'h000, 4'b1010, 32'h0);
        tbl[1]  = mk(8'b1100_0000, 32'h0,   26'h0,  16'h0,    32'h004, 4'b1010, 32'h0);
        tbl[2]  = mk(8'b1100_0000, 32'h0,   26'h0,  16'h0,    32'h008, 4'b1010, 32'h0);
        tbl[3]  = mk(8'b1100_1010, 32'h0,   26'h40, 16'h0,    32'h100, 4'b0000, 32'hC);
        tbl[4]  = mk(8'b1100_0100, 32'h0,   26'h0,  16'h0,    32'h100, 4'b1000, 32'hC);
        tbl[5]  = mk(8'b1100_0100, 32'h0,   26'h0,  16'hFFFF, 32'h100, 4'b0000, 32'hC);
        tbl[6]  = mk(8'b1100_0000, 32'h0,   26'h0,  16'h0,    32'h100, 4'b1000, 32'hC);
        tbl[7]  = mk(8'b1000_0000, 32'h0,   26'h0,  16'h0,    32'h100, 4'b1000, 32'hC);
        tbl[8]  = mk(8'b0100_0100, 32'h0,   26'h0,  16'h0010, 32'h100, 4'b1000, 32'hC);
        tbl[9]  = mk(8'b1101_0001, 32'h202, 26'h0,  16'h0,    32'h180, 4'b0110, 32'h0);
        tbl[10] = mk(8'b1100_0000, 32'h0,   26'h0,  16'h0,    32'h180, 4'b1010, 32'h0);
        tbl[11] = mk(8'b1101_0010, 32'h40,  26'h0,  16'h0,    32'h040, 4'b0000, 32'h184);
        tbl[12] = mk(8'b1100_0000, 32'h0,   26'h0,  16'h0,    32'h040, 4'b1000, 32'h184);
        tbl[13] = mk(8'b1000_0000, 32'h0,   26'h0,  16'h0,    32'h040, 4'b1000, 32'h184);
        tbl[14] = mk(8'b1000_0000, 32'h0,   26'h0,  16'h0,    32'h040, 4'b1000, 32'h184);
        tbl[15] = mk(8'b1000_0000, 32'h0,   26'h0,  16'h0,    32'h040, 4'b1000, 32'h184);
        tbl[16] = mk(8'b1111_0110, 32'h300, 26'h0,  16'h8,    32'h180, 4'b0010, 32'h0);
        tbl[17] = mk(8'b1100_0000, 32'h0,   26'h0,  16'h0,    32'h180, 4'b1010, 32'h0);
        tbl[18] = mk(8'b1100_0000, 32'h0,   26'h0,  16'h0,    32'h184, 4'b1010, 32'h0);

        do_reset();
        check("reset", RST_V, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 19; i++) apply($sformatf("tbl[%0d]", i), tbl[i]);

        // RAS: five linked jumps into a 4-deep stack, then five returns.
        do_reset();
        apply("ras_boot", mk(8'b1100_0000, 32'h0, 26'h0, 16'h0, 32'h0, 4'b1010, 32'h0));
        for (int k = 0; k < 5; k++) begin
            apply($sformatf("ras_push[%0d]", k),
                  mk(8'b1100_1010, 32'h0, 26'(push_pc[k] >> 2), 16'h0, push_pc[k],
                     {2'b00, 1'b0, (k >= 3)}, push_top[k]));
            apply($sformatf("ras_push_bubble[%0d]", k),
                  mk(8'b1100_0000, 32'h0, 26'h0, 16'h0, push_pc[k],
                     {2'b10, 1'b0, (k >= 3)}, push_top[k]));
        end
        for (int k = 0; k < 5; k++) begin
            apply($sformatf("ras_pop[%0d]", k),
                  mk(8'b1101_0001, 32'h200, 26'h0, 16'h0, 32'h200,
                     {2'b00, (k >= 3), 1'b0}, pop_top[k]));
            apply($sformatf("ras_pop_bubble[%0d]", k),
                  mk(8'b1100_0000, 32'h0, 26'h0, 16'h0, 32'h200,
                     {2'b10, (k >= 3), 1'b0}, pop_top[k]));
        end

        // Reset landing in a FLUSH bubble discards the pending redirect.
        apply("pre_rst_jmp", mk(8'b1100_1010, 32'h0, 26'h80, 16'h0, 32'h200, 4'b0000, 32'h204));
        rst = 1'b1;
        set_in(mk(8'b1111_1111, 32'h400, 26'h5, 16'h7, 32'h0, 4'h0, 32'h0));
        step();
        check("rst_in_flush", RST_V, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        rst = 1'b0;
        apply("post_rst_boot", mk(8'b1100_0000, 32'h0, 26'h0, 16'h0, 32'h0, 4'b1010, 32'h0));
        apply("post_rst_seq",  mk(8'b1100_0000, 32'h0, 26'h0, 16'h0, 32'h4, 4'b1010, 32'h0));

        // Random stimulus against the reference model.
        for (int c = 0; c < 4000; c++) begin
            logic [31:0] t;
            rst       = (c == 0) || ($urandom_range(0, 299) == 0);
            en        = ($urandom_range(0, 9) != 0);
            fetch_rdy = ($urandom_range(0, 3) != 0);
            exc_valid = ($urandom_range(0, 24) == 0);
            jr_valid  = ($urandom_range(0, 6) == 0);
            j_valid   = ($urandom_range(0, 6) == 0);
            br_taken  = ($urandom_range(0, 5) == 0);
            link      = ($urandom_range(0, 1) == 1);
            ret       = ($urandom_range(0, 1) == 1);
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            jr_target = t;
            j_index   = 26'($urandom);
            br_offset = 16'($urandom);
            model_step();
            step();
            check($sformatf("rand[%0d]", c), m_pc, m_fv, m_aerr, m_ras.size() == 0,
                  m_ras.size() == DEPTH, (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
